// File: rtl/ps_issuer_pkg.sv
// ps_issuer_pkg: shared types and helpers for the PS request issuer and its
// credit counter.
//   ps_issuer_state_t     - issuer state machine encoding
//   PS_REQ_READ/WRITE     - cmd_write encodings
//   credit_w(n)           - bits needed to hold a count of 0..n
package ps_issuer_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_BLOCKED = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_DRAINED = 2'd3
   } ps_issuer_state_t;

   localparam logic PS_REQ_READ  = 1'b0;
   localparam logic PS_REQ_WRITE = 1'b1;

   // Width of a counter that must represent 0..n inclusive.
   function automatic int unsigned credit_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/ps_credit_counter.sv
// ps_credit_counter: up/down credit counter bounded to 0..MAX.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   inc        - take one credit (ignored while full)
//   dec        - return one credit (ignored while empty)
//   count      - credits currently in use
//   full       - count == MAX
//   empty      - count == 0
//   underflow  - combinational: dec seen while empty
module ps_credit_counter
   import ps_issuer_pkg::*;
#(
   parameter int unsigned MAX = 128
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     inc,
   input  logic                     dec,
   output logic [credit_w(MAX)-1:0] count,
   output logic                     full,
   output logic                     empty,
   output logic                     underflow
);

   localparam int unsigned CW = credit_w(MAX);

   logic inc_eff;
   logic dec_eff;

   assign full      = (count == CW'(MAX));
   assign empty     = (count == '0);
   assign underflow = dec & empty;
   assign inc_eff   = inc & ~full;
   assign dec_eff   = dec & ~empty;

   // Simultaneous inc and dec cancel out.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc_eff && !dec_eff) begin
         count <= count + CW'(1);
      end else if (dec_eff && !inc_eff) begin
         count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/ps_request_issuer.sv
// ps_request_issuer: credit-based issuer of single-cycle PS read/write request
// pulses, one credit per response-FIFO entry so the FIFO cannot overflow.
// Optional watchdog: define PS_ISSUER_TIMEOUT_EN to add the sticky `timeout`
// output and its cycle counter.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   cmd_valid/cmd_ready           - command handshake
//   cmd_write, cmd_addr, cmd_wdata- command payload
//   ps_arvalid, ps_wvalid         - one-cycle request pulses (registered)
//   ps_addr, ps_wdata             - request payload, held between pulses
//   resp_pop                      - response consumed, returns a credit
//   drain_req, drained            - quiesce request / quiesced status
//   outstanding                   - credits in use
//   err_credit                    - sticky: pop seen with nothing outstanding
//   timeout                       - sticky watchdog (PS_ISSUER_TIMEOUT_EN only)
module ps_request_issuer
   import ps_issuer_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned CREDITS        = 128,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic                         cmd_write,
   input  logic [ADDR_WIDTH-1:0]        cmd_addr,
   input  logic [DATA_WIDTH-1:0]        cmd_wdata,
   output logic                         ps_arvalid,
   output logic                         ps_wvalid,
   output logic [ADDR_WIDTH-1:0]        ps_addr,
   output logic [DATA_WIDTH-1:0]        ps_wdata,
   input  logic                         resp_pop,
   input  logic                         drain_req,
   output logic                         drained,
   output logic [credit_w(CREDITS)-1:0] outstanding,
   output logic                         err_credit
`ifdef PS_ISSUER_TIMEOUT_EN
  ,output logic                         timeout
`endif
);

   localparam int unsigned CW = credit_w(CREDITS);

   ps_issuer_state_t state;
   ps_issuer_state_t state_nxt;

   logic accept;
   logic full;
   logic empty;
   logic underflow;
   logic pop_eff;

   assign accept  = cmd_valid & cmd_ready;
   assign pop_eff = resp_pop & ~empty;
   assign drained = (state == ST_DRAINED);

   ps_credit_counter #(
      .MAX (CREDITS)
   ) u_credits (
      .clk       (clk),
      .rst       (rst),
      .inc       (accept),
      .dec       (resp_pop),
      .count     (outstanding),
      .full      (full),
      .empty     (empty),
      .underflow (underflow)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and command acceptance. In RUN a raised drain_req withholds
   // ready so a command presented alongside it is never handshaken.
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      unique case (state)
         ST_RUN: begin
            cmd_ready = ~full & ~drain_req;
            if (drain_req) begin
               state_nxt = ST_DRAIN;
            end else if (accept && !pop_eff && (outstanding == CW'(CREDITS - 1))) begin
               state_nxt = ST_BLOCKED;
            end
         end
         ST_BLOCKED: begin
            if (drain_req) begin
               state_nxt = ST_DRAIN;
            end else if (resp_pop) begin
               state_nxt = ST_RUN;
            end
         end
         ST_DRAIN: begin
            // Also finishes on the pop that returns the last credit.
            if (empty || ((outstanding == CW'(1)) && resp_pop)) begin
               state_nxt = ST_DRAINED;
            end
         end
         ST_DRAINED: begin
            if (!drain_req) begin
               state_nxt = ST_RUN;
            end
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase
   end

   // Request pulses and held payload; write data only moves on writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         ps_arvalid <= 1'b0;
         ps_wvalid  <= 1'b0;
         ps_addr    <= '0;
         ps_wdata   <= '0;
      end else begin
         ps_arvalid <= accept & (cmd_write == PS_REQ_READ);
         ps_wvalid  <= accept & (cmd_write == PS_REQ_WRITE);
         if (accept) begin
            ps_addr <= cmd_addr;
            if (cmd_write == PS_REQ_WRITE) begin
               ps_wdata <= cmd_wdata;
            end
         end
      end
   end

   // Sticky credit error.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_credit <= 1'b0;
      end else if (underflow) begin
         err_credit <= 1'b1;
      end
   end

`ifdef PS_ISSUER_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] to_cnt;

   // Watchdog: counts cycles with credits out and no response progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt  <= '0;
         timeout <= 1'b0;
      end else begin
         if (resp_pop || empty) begin
            to_cnt <= '0;
         end else if (to_cnt != TW'(TIMEOUT_CYCLES)) begin
            to_cnt <= to_cnt + TW'(1);
         end
         if (!resp_pop && !empty && (to_cnt == TW'(TIMEOUT_CYCLES - 1))) begin
            timeout <= 1'b1;
         end
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

endmodule
